beat_player: RTL
================

Name: beat_player

Overview:
- Playback engine for the 16-step sequencer; the read side of the beats register that button presses write.
- Walks steps 0..15 at a fixed step period and, per step, decodes that step's 3-bit pitch code.
- Drives a gated square-wave tone, a step cursor and a step strobe for indicators and the audio pin.

Parameters:
STEPS, 16, number of steps; the beats bus is 3*STEPS bits wide.
STEP_TICKS, 3000000, clk cycles per step (250 ms at 12 MHz); must be >= 2.
GATE_TICKS, 2250000, cycles at the start of each step during which a non-rest note sounds; must satisfy 1 <= GATE_TICKS <= STEP_TICKS.
TONE_SHIFT, 0, right shift applied to the tone half-period table (for simulation speed-up); every shifted entry must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
beats  in  48  step k pitch code on bits [3k+2:3k]; 0 = rest
play_toggle  in  1  single-cycle pulse that toggles between stopped and playing
playing  out  1  high while in PLAY
step_idx  out  4  current step
step_strobe  out  1  high for the first cycle of every step
note_code  out  3  pitch code latched for the current step
gate  out  1  note sounding
tone_out  out  1  square-wave audio output

Behaviour:
- States: IDLE and PLAY. Reset asynchronously forces IDLE, and every output and counter to 0.
- IDLE, play_toggle=1 in cycle T: at the edge ending T, go to PLAY. Set tick_cnt=0, step_idx=0, note_code=beats[2:0] (value in cycle T), step_strobe=1.
- PLAY: tick_cnt counts 0..STEP_TICKS-1, so each step lasts exactly STEP_TICKS cycles. At the edge after tick STEP_TICKS-1:
  - step_idx increments (15 wraps to 0);
  - tick_cnt returns to 0;
  - note_code latches beats[3*idx_next+2 : 3*idx_next];
  - step_strobe pulses for one cycle.
- beats is sampled only at step start. Changes mid-step take effect at the next visit to that step.
- PLAY, play_toggle=1: at the next edge go to IDLE. playing, step_idx, note_code, step_strobe, gate, tone_out and tick_cnt all become 0. The next start always begins at step 0.
- If play_toggle coincides with tick STEP_TICKS-1, stop wins: no strobe and no advance.
- gate = playing AND (note_code != 0) AND (tick_cnt < GATE_TICKS). gate is decoded from registered state only and is glitch-free.
- Tone half-period H = TABLE[note_code] >> TONE_SHIFT. TABLE for codes 1..7 (C5..B5 at 12 MHz) is 11467, 10216, 9101, 8590, 7653, 6818, 6074.
- tone_out is registered and follows the step-relative tick: tone_out = gate AND (floor(tick_cnt / H) is odd).
  - Level 0 for ticks [0,H), 1 for [H,2H), and so on.
  - Implement with a half-period counter and phase flop, both reset at every step start.
  - tone_out is forced 0 whenever gate is low.
- Width rules:
  - tick_cnt width is clog2(STEP_TICKS).
  - The half-period counter is 14 bits.
  - Do not use divide/modulo hardware.
- Rest (code 0): strobe and step_idx still advance; gate and tone_out stay 0 for the whole step.
- Reset asserted mid-operation: outputs go to 0 immediately, without waiting for a clock. After rst_n deasserts, the block stays in IDLE until play_toggle.

Test Plan:
Bench parameters for all scenarios: STEP_TICKS=16, GATE_TICKS=12, TONE_SHIFT=10, giving H = 11, 9, 8, 8, 7, 6, 5 for codes 1..7.
1. Reset: hold rst_n=0, then release and idle 100 cycles with no toggle -> all outputs 0 throughout, playing=0.
2. Single note: beats=48'h7, toggle in cycle T -> cycle T+1: strobe=1, step_idx=0, note_code=7, playing=1. gate=1 for ticks 0..11 and 0 for ticks 12..15. tone_out=1 exactly on ticks 5..9, else 0.
3. Wrap: every step code 3 (beats=48'h6DB6DB6DB6DB), run 20 steps -> strobe every 16 cycles; step_idx 15 is followed by 0. Per step, tone_out=1 only on ticks 8..11.
4. Rest step: beats=48'h1C0 (step 2 = code 7, all others 0) -> steps 0, 1 and 3: strobe pulses but gate and tone_out stay 0. Step 2: gate=1 for 12 cycles.
5. Stop:
   - toggle at step 5 tick 3 -> next cycle all outputs 0.
   - toggle at tick 15 of any step -> no strobe and step_idx=0.
   - restart -> step_idx=0, note_code=beats[2:0].
6. Mid-step change and async reset:
   - rewrite beats[8:6] during step 2 -> note_code holds the old value until step 2 of the next loop.
   - assert rst_n low at tick 7 (not on an edge) -> outputs 0 before the next clk edge.

Source files
------------

// File: rtl/beat_player_if.sv
// Control/status bundle between the sequencer front end and the beat player.
// The front end (master) owns the beats register and the play toggle; the
// player (slave) reports cursor, strobe, note and audio back.
interface beat_player_if #(
  parameter int STEPS = 16
);
  localparam int IW = (STEPS > 1) ? $clog2(STEPS) : 1;

  logic [3*STEPS-1:0] beats;
  logic               play_toggle;
  logic               playing;
  logic [IW-1:0]      step_idx;
  logic               step_strobe;
  logic [2:0]         note_code;
  logic               gate;
  logic               tone_out;

  modport master (
    output beats, play_toggle,
    input  playing, step_idx, step_strobe, note_code, gate, tone_out
  );

  modport slave (
    input  beats, play_toggle,
    output playing, step_idx, step_strobe, note_code, gate, tone_out
  );
endinterface

// File: rtl/beat_player.sv
// 16-step playback engine: walks the beats register at a fixed step period,
// latches each step's pitch code at step start and produces a gated square
// wave whose phase restarts at every step.
module beat_player #(
  parameter int STEPS      = 16,
  parameter int STEP_TICKS = 3000000,
  parameter int GATE_TICKS = 2250000,
  parameter int TONE_SHIFT = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  beat_player_if.slave bus
);
  localparam int IW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int TW = $clog2(STEP_TICKS);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [IW-1:0] idx_q, idx_d, idx_nxt;
  logic [2:0]    note_q, note_d;
  logic          strobe_q, strobe_d;
  logic [13:0]   hcnt_q, hcnt_d;
  logic          phase_q, phase_d;
  logic          gate_q, gate_d;
  logic          tone_q, tone_d;
  logic [13:0]   half;

  // Tone half-period in clk cycles for a pitch code (C5..B5 at 12 MHz).
  function automatic logic [13:0] half_period(input logic [2:0] code);
    logic [13:0] base;
    case (code)
      3'd1:    base = 14'd11467;
      3'd2:    base = 14'd10216;
      3'd3:    base = 14'd9101;
      3'd4:    base = 14'd8590;
      3'd5:    base = 14'd7653;
      3'd6:    base = 14'd6818;
      3'd7:    base = 14'd6074;
      default: base = 14'd0;
    endcase
    // Rests never sound; any non-zero value keeps the counter compare sane.
    return (code == 3'd0) ? 14'd1 : (base >> TONE_SHIFT);
  endfunction

  assign half    = half_period(note_q);
  assign idx_nxt = (idx_q == IW'(STEPS - 1)) ? '0 : idx_q + 1'b1;

  // Next-state decode for the step sequencer, tone divider and outputs.
  always_comb begin
    // NOTE: every _d gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    tick_d   = tick_q;
    idx_d    = idx_q;
    note_d   = note_q;
    strobe_d = 1'b0;
    hcnt_d   = hcnt_q;
    phase_d  = phase_q;
    case (state_q)
      IDLE: begin
        if (bus.play_toggle) begin
          state_d  = PLAY;
          tick_d   = '0;
          idx_d    = '0;
          note_d   = bus.beats[2:0];
          strobe_d = 1'b1;
          hcnt_d   = '0;
          phase_d  = 1'b0;
        end
      end
      PLAY: begin
        if (bus.play_toggle) begin
          // Stop takes priority over a coincident step boundary.
          state_d = IDLE;
          tick_d  = '0;
          idx_d   = '0;
          note_d  = '0;
          hcnt_d  = '0;
          phase_d = 1'b0;
        end else if (tick_q == TW'(STEP_TICKS - 1)) begin
          tick_d   = '0;
          idx_d    = idx_nxt;
          note_d   = bus.beats[3*idx_nxt +: 3];
          strobe_d = 1'b1;
          hcnt_d   = '0;
          phase_d  = 1'b0;
        end else begin
          tick_d = tick_q + 1'b1;
          if (hcnt_q == half - 14'd1) begin
            hcnt_d  = '0;
            phase_d = ~phase_q;
          end else begin
            hcnt_d = hcnt_q + 14'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Gate and tone are computed from next state and registered, so the
    // pins come straight off flops and cannot glitch.
    gate_d = (state_d == PLAY) && (note_d != 3'd0) && (32'(tick_d) < GATE_TICKS);
    tone_d = gate_d & phase_d;
  end

  // State and output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      tick_q   <= '0;
      idx_q    <= '0;
      note_q   <= '0;
      strobe_q <= 1'b0;
      hcnt_q   <= '0;
      phase_q  <= 1'b0;
      gate_q   <= 1'b0;
      tone_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q  <= state_d;
      tick_q   <= tick_d;
      idx_q    <= idx_d;
      note_q   <= note_d;
      strobe_q <= strobe_d;
      hcnt_q   <= hcnt_d;
      phase_q  <= phase_d;
      gate_q   <= gate_d;
      tone_q   <= tone_d;
    end
  end

  assign bus.playing     = (state_q == PLAY);
  assign bus.step_idx    = idx_q;
  assign bus.step_strobe = strobe_q;
  assign bus.note_code   = note_q;
  assign bus.gate        = gate_q;
  assign bus.tone_out    = tone_q;
endmodule
